// File: rtl/hpdcache_fifo_beat_splitter_pkg.sv
// hpdcache_fifo_beat_splitter_pkg: shared types for the FIFO beat splitter
package hpdcache_fifo_beat_splitter_pkg;
  typedef enum logic {IDLE, SEND} hpdcache_splitter_state_e;
endpackage

// File: rtl/hpdcache_fifo_beat_splitter_mux.sv
// hpdcache_mux: one-of-N selector
//   sel_i  : index of the element to forward
//   data_i : N elements
//   data_o : selected element
module hpdcache_mux #(
  parameter int unsigned N = 2,
  parameter type data_t = logic,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [SW-1:0]  sel_i,
  input  data_t [N-1:0]  data_i,
  output data_t          data_o
);
  assign data_o = data_i[sel_i];
endmodule

// File: rtl/hpdcache_fifo_beat_splitter.sv
// hpdcache_fifo_beat_splitter: pops RATIO-beat entries from an upstream FIFO and writes them out one beat at a time
//   clk_i/rst_ni               : clock, async active-low reset
//   r_o/rok_i/rdata_i/rnbeats_i : upstream FIFO read port (rnbeats_i = valid beats - 1)
//   w_o/wok_i/wdata_o/wlast_o   : downstream FIFO write port, wlast_o marks the entry's last beat
//   busy_o                      : an entry is held and not yet fully sent
//   HPDCACHE_SPLITTER_FEEDTHROUGH_EN : beat 0 bypasses the hold registers in IDLE (zero latency)
//   HPDCACHE_ASSERT_OFF              : disables the embedded assertions
module hpdcache_fifo_beat_splitter
  import hpdcache_fifo_beat_splitter_pkg::*;
#(
  parameter int unsigned RATIO = 2,
  parameter type beat_t = logic,
  localparam int unsigned CW = $clog2(RATIO)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              r_o,
  input  logic              rok_i,
  input  beat_t [RATIO-1:0] rdata_i,
  input  logic [CW-1:0]     rnbeats_i,
  output logic              w_o,
  input  logic              wok_i,
  output beat_t             wdata_o,
  output logic              wlast_o,
  output logic              busy_o
);
  hpdcache_splitter_state_e state_q;
  logic [CW-1:0] cnt_q, nb_q, nb_in;
  beat_t [RATIO-1:0] hold_q;
  beat_t hold_beat;
  logic send, last_hold, pop, acc;
  // out-of-range beat counts (only reachable when RATIO is not a power of two) saturate
  assign nb_in = (32'(rnbeats_i) > RATIO - 1) ? CW'(RATIO - 1) : rnbeats_i;
  assign send = state_q == SEND;
  assign last_hold = cnt_q == nb_q;
  assign pop = r_o & rok_i;
  assign acc = w_o & wok_i;
  assign busy_o = send;
  hpdcache_mux #(.N(RATIO), .data_t(beat_t)) u_mux (
    .sel_i  (cnt_q),
    .data_i (hold_q),
    .data_o (hold_beat)
  );
`ifdef HPDCACHE_SPLITTER_FEEDTHROUGH_EN
  assign w_o = send | rok_i;
  assign wdata_o = send ? hold_beat : rdata_i[0];
  assign wlast_o = send ? last_hold : rok_i & (rnbeats_i == '0);
  assign r_o = send ? wok_i & last_hold : wok_i;
`else
  assign w_o = send;
  assign wdata_o = hold_beat;
  assign wlast_o = send & last_hold;
  // reload in the same cycle as the last beat so consecutive entries stream without a bubble
  assign r_o = ~send | (wok_i & last_hold);
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nb_q <= '0;
    end else if (pop) begin
      nb_q <= nb_in;
`ifdef HPDCACHE_SPLITTER_FEEDTHROUGH_EN
      // in IDLE beat 0 has already gone out through the bypass
      cnt_q <= (send || nb_in == '0) ? '0 : CW'(1);
      state_q <= (send || nb_in != '0) ? SEND : IDLE;
`else
      cnt_q <= '0;
      state_q <= SEND;
`endif
    end else if (acc) begin
      cnt_q <= last_hold ? '0 : cnt_q + CW'(1);
      state_q <= last_hold ? IDLE : SEND;
    end
  end
  always_ff @(posedge clk_i) begin
    if (pop) hold_q <= rdata_i;
  end
`ifndef HPDCACHE_ASSERT_OFF
  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) send |-> cnt_q <= nb_q);
  a_no_early_pop: assert property (@(posedge clk_i) disable iff (!rst_ni) (busy_o && !wlast_o) |-> !pop);
`endif
endmodule

// File: tb/tb_hpdcache_fifo_beat_splitter.sv
// tb_hpdcache_fifo_beat_splitter: table-driven and scoreboard checks of the beat splitter (RATIO=4, 8-bit beats)
module tb_hpdcache_fifo_beat_splitter;
  typedef logic [7:0] beat_t;
  typedef struct { logic [3:0][7:0] d; logic [1:0] nb; } ent_t;
  typedef struct { beat_t d; logic l; } exp_t;
  typedef struct { logic [3:0][7:0] d; logic [1:0] nb; int exp_n; } vec_t;
`ifdef HPDCACHE_SPLITTER_FEEDTHROUGH_EN
  localparam logic R_RST = 1'b0;
`else
  localparam logic R_RST = 1'b1;
`endif
  logic clk = 0, rst_n = 0;
  logic r, rok, w, wok, wlast, busy;
  logic [3:0][7:0] rdata;
  logic [1:0] rnbeats;
  beat_t wdata;
  ent_t drv_q[$];
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_beats = 0, first_cyc = 0, last_cyc = 0;
  hpdcache_fifo_beat_splitter #(.RATIO(4), .beat_t(beat_t)) dut (
    .clk_i(clk), .rst_ni(rst_n), .r_o(r), .rok_i(rok), .rdata_i(rdata), .rnbeats_i(rnbeats),
    .w_o(w), .wok_i(wok), .wdata_o(wdata), .wlast_o(wlast), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  initial begin
    bit pop_now;
    exp_t e;
    rok = 0; rdata = '0; rnbeats = '0;
    forever begin
      @(negedge clk);
      cyc++;
      pop_now = rst_n && r && rok;
      if (pop_now)
        for (int i = 0; i <= int'(rnbeats); i++) exp_q.push_back('{rdata[i], i == int'(rnbeats)});
      if (rst_n && w && wok) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stray beat: got %0h expected none", wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", 32'(wdata), 32'(e.d));
          chk("wlast", 32'(wlast), 32'(e.l));
          if (e.l) chk("r_o on last beat", 32'(r), 1);
          n_beats++;
          if (n_beats == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
      if (rst_n && busy && !wlast) chk("r_o mid-entry", 32'(r), 0);
      @(posedge clk); #1;
      if (pop_now && drv_q.size() > 0) drv_q.delete(0);
      rok = rst_n && drv_q.size() > 0;
      if (drv_q.size() > 0) begin
        rdata = drv_q[0].d;
        rnbeats = drv_q[0].nb;
      end
    end
  end
  task automatic wait_idle();
    int t;
    for (t = 0; t < 60; t++) begin
      @(negedge clk);
      if (drv_q.size() == 0 && exp_q.size() == 0 && !busy) break;
    end
    chk("drain timeout", 32'(t < 60), 1);
    @(posedge clk); #1;
  endtask
  task automatic wait_beats(input int n);
    int t;
    for (t = 0; t < 60 && n_beats < n; t++) @(posedge clk);
    chk("beat wait timeout", 32'(n_beats >= n), 1);
    #1;
  endtask
  vec_t vecs[6];
  initial begin
    vecs[0] = '{32'hD4C3B2A1, 2'd3, 4};
    vecs[1] = '{32'h44332211, 2'd0, 1};
    vecs[2] = '{32'h88776655, 2'd1, 2};
    vecs[3] = '{32'hCCBBAA99, 2'd2, 3};
    vecs[4] = '{32'h0F0E0D0C, 2'd3, 4};
    vecs[5] = '{32'hFFFFFF00, 2'd0, 1};
    wok = 0;
    repeat (2) @(negedge clk);
    chk("reset w_o", 32'(w), 0);
    chk("reset wlast_o", 32'(wlast), 0);
    chk("reset busy_o", 32'(busy), 0);
    chk("reset r_o", 32'(r), 32'(R_RST));
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post-reset w_o", 32'(w), 0);
    chk("post-reset r_o", 32'(r), 32'(R_RST));
    @(posedge clk); #1 wok = 1;
    foreach (vecs[k]) begin
      n_beats = 0;
      drv_q.push_back('{vecs[k].d, vecs[k].nb});
      wait_idle();
      chk("vec beat count", 32'(n_beats), 32'(vecs[k].exp_n));
      chk("vec beats contiguous", 32'(last_cyc - first_cyc), 32'(vecs[k].exp_n - 1));
      chk("vec busy after", 32'(busy), 0);
    end
    n_beats = 0;
    drv_q.push_back('{32'hD4C3B2A1, 2'd3});
    drv_q.push_back('{32'h00006655, 2'd1});
    wait_idle();
    chk("b2b beat count", 32'(n_beats), 6);
    chk("b2b no gap", 32'(last_cyc - first_cyc), 5);
    n_beats = 0;
    drv_q.push_back('{32'h000000E1, 2'd0});
    drv_q.push_back('{32'h00F3F2F1, 2'd2});
    wait_idle();
    chk("single+reload beat count", 32'(n_beats), 4);
    chk("single+reload no gap", 32'(last_cyc - first_cyc), 3);
    n_beats = 0;
    drv_q.push_back('{32'hD4C3B2A1, 2'd3});
    wait_beats(1);
    wok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall w_o", 32'(w), 1);
      chk("stall wdata_o", 32'(wdata), 32'hB2);
      chk("stall wlast_o", 32'(wlast), 0);
    end
    @(posedge clk); #1 wok = 1;
    wait_idle();
    chk("stall beat count", 32'(n_beats), 4);
    n_beats = 0;
    drv_q.push_back('{32'hD4C3B2A1, 2'd3});
    wait_beats(2);
    rst_n = 0;
    wok = 0;
    exp_q.delete();
    @(negedge clk);
    chk("mid-reset w_o", 32'(w), 0);
    chk("mid-reset busy_o", 32'(busy), 0);
    chk("mid-reset wlast_o", 32'(wlast), 0);
    chk("mid-reset r_o", 32'(r), 32'(R_RST));
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("after reset w_o", 32'(w), 0);
    chk("after reset r_o", 32'(r), 32'(R_RST));
    @(posedge clk); #1 wok = 1;
    repeat (8) @(negedge clk);
    chk("no beats after reset", 32'(n_beats), 2);
    chk("idle after reset", 32'(busy), 0);
`ifdef HPDCACHE_SPLITTER_FEEDTHROUGH_EN
    begin
      int t;
      n_beats = 0;
      drv_q.push_back('{32'h5A4B3C2D, 2'd3});
      for (t = 0; t < 4 && !rok; t++) @(negedge clk);
      chk("ft rok timeout", 32'(rok), 1);
      chk("ft same-cycle wdata", 32'(wdata), 32'h2D);
      chk("ft same-cycle r_o", 32'(r), 1);
      chk("ft same-cycle w_o", 32'(w), 1);
      wait_idle();
      chk("ft beat count", 32'(n_beats), 4);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
